// File: rtl/rst_seq_gen_pkg.sv
// Shared types and constants for the reset sequencer.
//   rst_seq_state_t : sequencer FSM state encoding
//   rst_tick_cnt_t  : per-channel tick counter, wide enough for the largest STEP_W
//   NUM_RST_CH      : default number of sequenced reset channels
//   RST_TICK_HZ     : default sequencing tick rate in Hz
package top_pkg;

    localparam int unsigned NUM_RST_CH  = 4;
    localparam int unsigned RST_TICK_HZ = 1_000;

    // Widest STEP_W the sequencer supports; narrower builds saturate below this.
    localparam int unsigned RST_CNT_W = 16;

    typedef logic [RST_CNT_W-1:0] rst_tick_cnt_t;

    typedef enum logic [1:0] {
        StIdle,
        StSeqUp,
        StRun,
        StSeqDn
    } rst_seq_state_t;

    // Increment that holds at lim instead of wrapping.
    function automatic rst_tick_cnt_t sat_inc(rst_tick_cnt_t v, rst_tick_cnt_t lim);
        rst_tick_cnt_t r;
        r = (v >= lim) ? v : v + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rst_seq_gen_tick_gen.sv
// Prescaler producing a one-cycle strobe every CLK_HZ/TICK_HZ clocks.
// Ports:
//   clk_100  : clock
//   areset_n : asynchronous active-low reset
//   tick     : high for one cycle when the count reaches DIV-1
module tick_gen #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1_000
) (
    input  logic clk_100,
    input  logic areset_n,
    output logic tick
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $error("tick_gen: CLK_HZ/TICK_HZ must be at least 2");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = (count_q == CNT_LAST) ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk_100 or negedge areset_n) begin
        if (!areset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Decoded from the count so reset forces it low immediately.
    assign tick = (count_q == CNT_LAST);

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: releases NUM_CH active-low resets in ascending order, each
// channel waiting its own ch_delay (in ticks) after the previous one.
// Optional feature macro: RST_SEQ_PWRDN_EN -- when defined, stop re-asserts the
// released channels in descending order with the same per-channel delays;
// otherwise stop drops every channel at once.
// Ports:
//   clk_100  : clock
//   areset_n : asynchronous active-low reset
//   start    : one-cycle request to run the up-sequence (IDLE only)
//   stop     : one-cycle request to run the down-sequence (wins over start)
//   ch_delay : per-channel delay in ticks, quasi-static
//   tick     : prescaler strobe at TICK_HZ
//   ch_rst_n : per-channel active-low resets, thermometer coded
//   busy     : up- or down-sequence in progress
//   done     : all channels released
module rst_seq_gen
    import top_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ    = RST_TICK_HZ,
    parameter int unsigned NUM_CH     = NUM_RST_CH,
    parameter int unsigned STEP_W     = 8,
    parameter int unsigned AUTO_START = 1
) (
    input  logic                           clk_100,
    input  logic                           areset_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic [NUM_CH-1:0][STEP_W-1:0]  ch_delay,
    output logic                           tick,
    output logic [NUM_CH-1:0]              ch_rst_n,
    output logic                           busy,
    output logic                           done
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_ch_check
        $error("rst_seq_gen: NUM_CH must be 1..16");
    end
    if (STEP_W < 1 || STEP_W > RST_CNT_W) begin : g_step_check
        $error("rst_seq_gen: STEP_W out of range");
    end

    // idx must be able to hold NUM_CH: "all channels released".
    localparam int unsigned IDX_W = $clog2(NUM_CH + 1);
    localparam logic [IDX_W-1:0] IDX_ALL = IDX_W'(NUM_CH);
    localparam rst_tick_cnt_t CNT_MAX = rst_tick_cnt_t'((32'd1 << STEP_W) - 32'd1);

    rst_seq_state_t      state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    rst_tick_cnt_t       cnt_q, cnt_d;
    logic [NUM_CH-1:0]   ch_rst_n_q, ch_rst_n_d;
    logic                auto_pend_q;
    rst_tick_cnt_t       cur_delay;
    logic                hit;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk_100  (clk_100),
        .areset_n (areset_n),
        .tick     (tick)
    );

    // Live delay of the channel currently pending.
    always_comb begin
        cur_delay = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_delay = rst_tick_cnt_t'(ch_delay[k]);
            end
        end
    end

    assign hit = (cnt_q == cur_delay);

    // State register
    always_ff @(posedge clk_100 or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            ch_rst_n_q  <= '0;
            auto_pend_q <= (AUTO_START != 0);
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            ch_rst_n_q  <= ch_rst_n_d;
            auto_pend_q <= 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        ch_rst_n_d = ch_rst_n_q;

        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                cnt_d = '0;
                if (!stop && (start || auto_pend_q)) begin
                    state_d = StSeqUp;
                end
            end

            StSeqUp, StRun: begin
                if (stop) begin
                    state_d = StSeqDn;
                    cnt_d   = '0;
`ifdef RST_SEQ_PWRDN_EN
                    // Highest released channel is one below the release pointer.
                    idx_d = (idx_q == '0) ? '0 : idx_q - 1'b1;
`else
                    idx_d      = '0;
                    ch_rst_n_d = '0;
`endif
                end else if (state_q == StSeqUp) begin
                    if (idx_q == IDX_ALL) begin
                        state_d = StRun;
                    end else if (hit) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                ch_rst_n_d[k] = 1'b1;
                            end
                        end
                        idx_d = idx_q + 1'b1;
                        cnt_d = '0;
                    end else if (tick) begin
                        cnt_d = sat_inc(cnt_q, CNT_MAX);
                    end
                end
            end

            StSeqDn: begin
`ifdef RST_SEQ_PWRDN_EN
                if (!ch_rst_n_q[0]) begin
                    // Aborted before any channel was released.
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (hit) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            ch_rst_n_d[k] = 1'b0;
                        end
                    end
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end else if (tick) begin
                    cnt_d = sat_inc(cnt_q, CNT_MAX);
                end
`else
                state_d = StIdle;
                idx_d   = '0;
                cnt_d   = '0;
`endif
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy     = (state_q == StSeqUp) || (state_q == StSeqDn);
        done     = (state_q == StRun);
        ch_rst_n = ch_rst_n_q;
    end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboard bench for rst_seq_gen: expected {done,busy,ch_rst_n} changes are
// computed from tick arithmetic and queued; a monitor pops one per observed change.
module tb_rst_seq_gen;

    localparam int NCH  = 4;
    localparam int SW   = 4;
    localparam int DIVC = 10;

    logic                     clk_100  = 1'b0;
    logic                     areset_n = 1'b0;
    logic                     start    = 1'b0;
    logic                     stop     = 1'b0;
    logic [NCH-1:0][SW-1:0]   ch_delay;
    logic                     tick;
    logic [NCH-1:0]           ch_rst_n;
    logic                     busy;
    logic                     done;

    rst_seq_gen #(
        .CLK_HZ     (100),
        .TICK_HZ    (10),
        .NUM_CH     (NCH),
        .STEP_W     (SW),
        .AUTO_START (1)
    ) dut (
        .clk_100  (clk_100),
        .areset_n (areset_n),
        .start    (start),
        .stop     (stop),
        .ch_delay (ch_delay),
        .tick     (tick),
        .ch_rst_n (ch_rst_n),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  dly[NCH];
    int  rel[NCH];
    int  c;
    int  last;

    // Edge count since reset release: edge 1 is the first rising edge.
    always @(posedge clk_100) begin
        if (!areset_n) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [3:0] therm(input int n);
        logic [3:0] t;
        t = 4'((1 << n) - 1);
        return t;
    endfunction

    // Edge at which a channel pending since edge p with delay d changes.
    // Ticks are sampled at edges that are multiples of DIVC.
    function automatic int rel_edge(input int p, input int d);
        if (d == 0) return p + 1;
        return DIVC * (p / DIVC + 1) + DIVC * (d - 1) + 1;
    endfunction

    task automatic push(input int t, input logic d, input logic b, input logic [3:0] ch);
        ev_t e;
        e.cyc = t;
        e.vec = {d, b, ch};
        exp_q.push_back(e);
    endtask

    task automatic model_up(input int e, input int nrel, output int lst);
        int p;
        push(e, 1'b0, 1'b1, 4'h0);
        p = e;
        for (int k = 0; k < NCH; k++) begin
            rel[k] = rel_edge(p, dly[k]);
            if (k < nrel) push(rel[k], 1'b0, 1'b1, therm(k + 1));
            p = rel[k];
        end
        if (nrel == NCH) push(rel[NCH-1] + 1, 1'b1, 1'b0, 4'hF);
        lst = rel[NCH-1] + 1;
    endtask

    task automatic model_dn(input int s, input int nrel, input bit from_run, output int lst);
`ifdef RST_SEQ_PWRDN_EN
        int p;
        int r;
        p = s;
        if (from_run) push(s, 1'b0, 1'b1, therm(nrel));
        for (int k = nrel - 1; k >= 0; k--) begin
            r = rel_edge(p, dly[k]);
            push(r, 1'b0, (k != 0), therm(k));
            p = r;
        end
        lst = p;
`else
        if (from_run || nrel > 0) push(s, 1'b0, 1'b1, 4'h0);
        push(s + 1, 1'b0, 1'b0, 4'h0);
        lst = s + 1;
`endif
    endtask

    task automatic apply_delays();
        for (int k = 0; k < NCH; k++) ch_delay[k] = SW'(dly[k]);
    endtask

    task automatic run_until(input int t);
        while (cyc < t) begin
            @(posedge clk_100);
            #1;
        end
    endtask

    task automatic drain(input string name, input int t);
        run_until(t + 2);
        chk(name, exp_q.size(), 0);
    endtask

    task automatic pulse(input logic st, input logic sp);
        start = st;
        stop  = sp;
        @(posedge clk_100);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Monitor: tick cadence, thermometer shape, and scoreboard of output changes.
    initial begin
        logic [5:0] prev;
        logic [5:0] cur;
        ev_t        e;
        prev = '0;
        forever begin
            @(posedge clk_100);
            #1;
            if (!areset_n) begin
                prev = '0;
            end else begin
                chk("tick", int'(tick), int'((cyc % DIVC) == DIVC - 1));
                chk("thermo", int'((ch_rst_n & (ch_rst_n + 4'd1)) == 4'd0), 1);
                cur = {done, busy, ch_rst_n};
                if (cur != prev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_change", int'(cur), int'(prev));
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_cycle", cyc, e.cyc);
                        chk("event_value", int'(cur), int'(e.vec));
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        dly = '{0, 1, 2, 3};
        apply_delays();
        repeat (3) @(posedge clk_100);
        #1;
        chk("reset_outputs", int'({tick, done, busy, ch_rst_n}), 0);

        // Auto-start after release, then full power-down from RUN.
        @(negedge clk_100);
        areset_n = 1'b1;
        model_up(1, NCH, last);
        drain("auto_up", last);
        c = cyc;
        model_dn(c + 1, NCH, 1'b1, last);
        pulse(1'b0, 1'b1);
        drain("dn_from_run", last);
        chk("idle_busy", int'(busy), 0);

        // Random delays; start during RUN must be ignored.
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < NCH; k++) dly[k] = int'($urandom_range(0, 4));
            apply_delays();
            c = cyc;
            model_up(c + 1, NCH, last);
            pulse(1'b1, 1'b0);
            drain("rand_up", last);
            pulse(1'b1, 1'b0);
            run_until(cyc + 3);
            c = cyc;
            model_dn(c + 1, NCH, 1'b1, last);
            pulse(1'b0, 1'b1);
            drain("rand_dn", last);
        end

        // start+stop together in IDLE, and stop alone in IDLE: nothing runs.
        pulse(1'b1, 1'b1);
        pulse(1'b0, 1'b1);
        c = cyc;
        drain("collision", c + 30);
        chk("collision_busy", int'(busy), 0);

        // Abort after two channels released.
        for (int k = 0; k < NCH; k++) dly[k] = int'($urandom_range(0, 3));
        apply_delays();
        c = cyc;
        model_up(c + 1, 2, last);
        pulse(1'b1, 1'b0);
        run_until(rel[1]);
        c = cyc;
        model_dn(c + 1, 2, 1'b0, last);
        pulse(1'b0, 1'b1);
        drain("abort", last);

        // Asynchronous reset mid up-sequence, then auto-restart.
        c = cyc;
        model_up(c + 1, NCH, last);
        pulse(1'b1, 1'b0);
        run_until(rel[1]);
        #2;
        areset_n = 1'b0;
        #1;
        chk("async_reset", int'({tick, done, busy, ch_rst_n}), 0);
        exp_q.delete();
        repeat (2) @(negedge clk_100);
        areset_n = 1'b1;
        model_up(1, NCH, last);
        drain("restart", last);
        chk("restart_done", int'(done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_seq_gen.md
RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1_000, sequencing tick rate in Hz; DIV = CLK_HZ/TICK_HZ.
REQ-003 SHALL have parameter NUM_CH, default 4, number of sequenced reset channels (1..16).
REQ-004 SHALL have parameter STEP_W, default 8, width of each per-channel delay field.
REQ-005 SHALL have parameter AUTO_START, default 1, where 1 means the up-sequence starts by itself after reset release.
REQ-006 SHALL have port: clk_100  input  1  sole clock; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port: areset_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port: start  input  1  single-cycle request to run the up-sequence.
REQ-009 SHALL have port: stop  input  1  single-cycle request to run the down-sequence.
REQ-010 SHALL have port: ch_delay  input  NUM_CH x STEP_W  per-channel delay in ticks; quasi-static.
REQ-011 SHALL have port: tick  output  1  one-cycle strobe at TICK_HZ.
REQ-012 SHALL have port: ch_rst_n  output  NUM_CH  per-channel active-low reset.
REQ-013 SHALL have port: busy  output  1  high while the up-sequence or down-sequence is running.
REQ-014 SHALL have port: done  output  1  high while all channels are released.

Function
REQ-015 Prescaler counts 0..DIV-1; tick is high for exactly one cycle when count==DIV-1, then count wraps to 0.
REQ-016 Prescaler counter width is $clog2(DIV); synthesis fails if DIV<2.
REQ-017 FSM has four states: IDLE, SEQ_UP, RUN, SEQ_DN.
REQ-018 Transitions:
- IDLE->SEQ_UP on start, or one cycle after reset release when AUTO_START=1.
- SEQ_UP->RUN after the last channel is released.
- RUN->SEQ_DN on stop.
- SEQ_DN->IDLE after channel 0 is asserted.
REQ-019 SEQ_UP: channel index idx runs 0 to NUM_CH-1 and a tick counter cnt is cleared on entry to each channel.
- Each tick increments cnt.
- When cnt==ch_delay[idx], the next clock sets ch_rst_n[idx]=1, increments idx and clears cnt.
- A delay of 0 releases the channel on the cycle after entry, with no tick required.
REQ-020 Release order is strictly ascending; ch_rst_n is thermometer-coded at all times (bit k high implies bits 0..k-1 high).
REQ-021 done=1 only in RUN; busy=1 only in SEQ_UP or SEQ_DN.
REQ-022 start is ignored outside IDLE; stop is ignored in IDLE.
REQ-023 If start and stop are high in the same cycle, stop wins.
REQ-024 stop during SEQ_UP aborts the up-sequence; down-sequencing starts from the highest released channel (per Configuration).
REQ-025 ch_delay[idx] is compared live; a change while channel idx is pending takes effect on the next compare.
REQ-026 cnt saturates at 2^STEP_W-1 and never wraps.

Reset
REQ-027 On areset_n=0, asynchronously set:
- ch_rst_n='0, tick=0, busy=0, done=0
- state=IDLE, idx=0, cnt=0, prescaler=0
REQ-028 Reset asserted mid-sequence returns every output to its reset value immediately, with no down-sequence.

Configuration
REQ-029 With macro RST_SEQ_PWRDN_EN defined, SEQ_DN asserts channels in descending order.
- Channel k is asserted ch_delay[k] ticks after channel k+1 was asserted.
- The highest released channel waits ch_delay[k] ticks after stop.
REQ-030 Without RST_SEQ_PWRDN_EN, stop drives ch_rst_n='0 on the next clock and the FSM goes to IDLE via a single SEQ_DN cycle (busy high one cycle).

Structure
REQ-031 top_pkg SHALL hold:
- rst_seq_state_t enum
- the tick-counter typedef
- constants NUM_RST_CH and RST_TICK_HZ used by the top level.
REQ-032 Prescaler SHALL be a sub-module tick_gen (parameters CLK_HZ, TICK_HZ; ports clk_100, areset_n, tick).
REQ-033 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-034 Tick: CLK_HZ=100, TICK_HZ=10 -> tick high one cycle every 10 cycles, first tick on cycle 10 after reset release.
REQ-035 Auto-sequence: NUM_CH=4, ch_delay={0,1,2,3}, AUTO_START=1 ->
- releases in order 0,1,2,3 with spacing 0,1,2,3 ticks
- done rises the cycle after ch_rst_n=4'b1111
- ch_rst_n stays thermometer-coded throughout.
REQ-036 Power-down with RST_SEQ_PWRDN_EN: stop in RUN -> channels assert 3,2,1,0 with spacing 3,2,1,0 ticks, then IDLE, busy low.
REQ-037 Power-down without macro: stop in RUN -> ch_rst_n=4'b0000 one cycle later, busy high exactly one cycle.
REQ-038 Collisions:
- start and stop in the same cycle in IDLE -> no sequence runs.
- stop after 2 channels are released in SEQ_UP -> only channels 1,0 are re-asserted.
REQ-039 Mid-sequence reset: areset_n pulsed low in SEQ_UP -> all outputs 0 asynchronously; auto-restart from channel 0 after release.
